// File: rtl/cc_lane_speed_ticker.sv
// ---------------------------------------------------------------------------
// cc_lane_speed_ticker
//
// Multi-lane, level-dependent speed tick generator. Each object lane has its
// own free-running prescaler. A lane emits a one-cycle tick each time its
// counter wraps from its terminal count back to zero. The terminal count
// shrinks as the level rises and as the lane index rises, so higher levels and
// higher lanes move faster:
//   shift(L) = min(L-1, MAX_SHIFT)
//   TC[i]    = 2^(DATAWIDTH - shift(L) - i) - 1
//
// Ports
//   CLOCK_50        in   1           system clock, rising edge
//   RESET_InLow     in   1           asynchronous reset, active-low
//   enable_In       in   1           1 = counters run, 0 = hold (phase kept)
//   clear_In        in   1           synchronous restart of every lane counter
//   numLevel_In     in   3           current level code (valid 1..NUM_LEVELS)
//   tick_OutBUS     out  NUM_LANES   per-lane one-cycle tick, registered
//   levelValid_Out  out  1           registered "input level is in range"
//   count0_OutBUS   out  DATAWIDTH   lane 0 counter value, for observability
//
// Per-lane update priority, each clock:
//   1. clear or level change        -> cnt = 0, tick = 0
//   2. latched level out of range   -> cnt = 0, tick = 0
//   3. not enabled                  -> cnt holds, tick = 0
//   4. cnt == TC[i]                 -> cnt = 0, tick = 1
//   5. otherwise                    -> cnt = cnt + 1, tick = 0
// ---------------------------------------------------------------------------
module cc_lane_speed_ticker #(
    parameter int DATAWIDTH  = 25,
    parameter int NUM_LANES  = 4,
    parameter int NUM_LEVELS = 4,
    parameter int MAX_SHIFT  = 2
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_InLow,
    input  logic                 enable_In,
    input  logic                 clear_In,
    input  logic [2:0]           numLevel_In,
    output logic [NUM_LANES-1:0] tick_OutBUS,
    output logic                 levelValid_Out,
    output logic [DATAWIDTH-1:0] count0_OutBUS
);

    localparam logic [2:0]           MAX_LEVEL_W = 3'(NUM_LEVELS);
    localparam logic [2:0]           MAX_SHIFT_W = 3'(MAX_SHIFT);
    localparam logic [DATAWIDTH-1:0] ALL_ONES    = {DATAWIDTH{1'b1}};

    logic [2:0]           r_level_q;
    logic                 r_level_valid;
    logic [NUM_LANES-1:0] r_tick;
    logic [DATAWIDTH-1:0] r_cnt [NUM_LANES];

    logic                 w_chg;
    logic                 w_latched_ok;
    logic                 w_input_ok;
    logic [2:0]           w_level_m1;
    logic [2:0]           w_shift;
    logic [DATAWIDTH-1:0] w_tc [NUM_LANES];

    assign w_chg        = (numLevel_In != r_level_q);
    assign w_latched_ok = (r_level_q != 3'd0) && (r_level_q <= MAX_LEVEL_W);
    assign w_input_ok   = (numLevel_In != 3'd0) && (numLevel_In <= MAX_LEVEL_W);
    assign w_level_m1   = r_level_q - 3'd1;

    // Level 0 wraps w_level_m1 to 7 and gets capped; the value is irrelevant
    // because an invalid latched level forces every counter to zero anyway.
    always_comb begin
        w_shift = w_level_m1;
        if (w_level_m1 > MAX_SHIFT_W) begin
            w_shift = MAX_SHIFT_W;
        end
    end

    // 2^(DATAWIDTH-k)-1 is just the all-ones word shifted right by k, which
    // keeps the unused MSBs of the terminal count at zero.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            w_tc[i] = ALL_ONES >> (int'(w_shift) + i);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            r_level_q     <= 3'd0;
            r_level_valid <= 1'b0;
            r_tick        <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_level_q     <= numLevel_In;
            r_level_valid <= w_input_ok;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (clear_In || w_chg || !w_latched_ok) begin
                    r_cnt[i]  <= '0;
                    r_tick[i] <= 1'b0;
                end else if (!enable_In) begin
                    r_tick[i] <= 1'b0;
                end else if (r_cnt[i] == w_tc[i]) begin
                    r_cnt[i]  <= '0;
                    r_tick[i] <= 1'b1;
                end else begin
                    r_cnt[i]  <= r_cnt[i] + 1'b1;
                    r_tick[i] <= 1'b0;
                end
            end
        end
    end

    assign tick_OutBUS    = r_tick;
    assign levelValid_Out = r_level_valid;
    assign count0_OutBUS  = r_cnt[0];

endmodule

// File: tb/tb_cc_lane_speed_ticker.sv
module tb_cc_lane_speed_ticker;

    localparam int DW    = 6;
    localparam int LANES = 4;
    localparam int NLEV  = 4;
    localparam int MSH   = 2;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             clr;
    logic [2:0]       lvl;
    logic [LANES-1:0] tick;
    logic             lvl_valid;
    logic [DW-1:0]    cnt0;

    int n_vectors;
    int n_miscompares;

    // Reference model: each lane counts enabled edges since its last restart;
    // a tick lands whenever that count is a non-zero multiple of the period.
    int         m_elapsed [LANES];
    int         m_lvl_q;
    logic [3:0] m_tick;
    logic       m_valid;

    cc_lane_speed_ticker #(
        .DATAWIDTH (DW),
        .NUM_LANES (LANES),
        .NUM_LEVELS(NLEV),
        .MAX_SHIFT (MSH)
    ) dut (
        .CLOCK_50      (clk),
        .RESET_InLow   (rst_n),
        .enable_In     (en),
        .clear_In      (clr),
        .numLevel_In   (lvl),
        .tick_OutBUS   (tick),
        .levelValid_Out(lvl_valid),
        .count0_OutBUS (cnt0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int period(input int level, input int lane);
        int sh;
        sh = (level - 1 > MSH) ? MSH : level - 1;
        return 1 << (DW - sh - lane);
    endfunction

    function automatic bit level_ok(input int level);
        return (level >= 1) && (level <= NLEV);
    endfunction

    function automatic int exp_cnt0();
        if (m_elapsed[0] == 0) return 0;
        return m_elapsed[0] % period(m_lvl_q, 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) m_elapsed[i] = 0;
        m_tick  = '0;
        m_valid = 1'b0;
        m_lvl_q = 0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (clr || (int'(lvl) != m_lvl_q) || !level_ok(m_lvl_q)) begin
                    m_elapsed[i] = 0;
                    m_tick[i]    = 1'b0;
                end else if (!en) begin
                    m_tick[i] = 1'b0;
                end else begin
                    m_elapsed[i] = m_elapsed[i] + 1;
                    m_tick[i]    = (m_elapsed[i] % period(m_lvl_q, i)) == 0;
                end
            end
            m_valid = level_ok(int'(lvl));
            m_lvl_q = int'(lvl);
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        check_eq("tick", 32'(tick), 32'(m_tick));
        check_eq("count0", 32'(cnt0), 32'(exp_cnt0()));
        check_eq("level_valid", 32'(lvl_valid), 32'(m_valid));
    endtask

    // driver: apply inputs, take one edge, compare #1 after it
    task automatic step(input logic e, input logic c, input logic [2:0] l);
        en  = e;
        clr = c;
        lvl = l;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n, input logic [2:0] l);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, l);
    endtask

    // bounded wait for the modelled lane 0 count to hit a target
    task automatic run_until_cnt0(input int target, input logic [2:0] l);
        for (int k = 0; k < 200; k++) begin
            if (exp_cnt0() == target) break;
            step(1'b1, 1'b0, l);
        end
        check_eq("reach_cnt0", 32'(cnt0), 32'(target));
    endtask

    int tick_tally;

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        model_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        lvl   = 3'd0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // 1: run level 1, then reset mid-count between edges
        run(100, 3'd1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst_tick", 32'(tick), 32'd0);
        check_eq("async_rst_cnt0", 32'(cnt0), 32'd0);
        check_eq("async_rst_valid", 32'(lvl_valid), 32'd0);
        step(1'b1, 1'b0, 3'd1);
        step(1'b1, 1'b0, 3'd1);
        rst_n = 1'b1;
        run(2, 3'd1);
        // lane 0 restarted: over the next 128 edges lane 3 ticks 16 times
        tick_tally = 0;
        for (int k = 0; k < 128; k++) begin
            step(1'b1, 1'b0, 3'd1);
            if (tick[3]) tick_tally++;
        end
        check_eq("lane3_ticks_128", 32'(tick_tally), 32'd16);

        // 2: level 1 -> 3 at count0 = 40, then level 4
        run_until_cnt0(40, 3'd1);
        step(1'b1, 1'b0, 3'd3);
        check_eq("lvlchg_cnt0", 32'(cnt0), 32'd0);
        check_eq("lvlchg_tick", 32'(tick), 32'd0);
        run(64, 3'd3);
        run(64, 3'd4);

        // 3: pause at count0 = 5, level 1
        step(1'b1, 1'b0, 3'd1);
        run_until_cnt0(5, 3'd1);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 3'd1);
        check_eq("pause_hold", 32'(cnt0), 32'd5);
        run(70, 3'd1);

        // 4: clear exactly at the terminal count, then clear with level change
        run_until_cnt0(63, 3'd1);
        step(1'b1, 1'b1, 3'd1);
        check_eq("clr_at_tc_tick", 32'(tick), 32'd0);
        run(40, 3'd1);
        step(1'b1, 1'b1, 3'd2);
        run(40, 3'd2);

        // 5: invalid levels produce nothing
        tick_tally = 0;
        for (int k = 0; k < 200; k++) begin
            step(1'b1, 1'b0, (k < 100) ? 3'd0 : 3'd5);
            if (tick != '0) tick_tally++;
        end
        check_eq("invalid_no_ticks", 32'(tick_tally), 32'd0);
        run(100, 3'd2);

        // random: enable mostly high, rare clear, rare level change (0..7)
        lvl = 3'(1 + $urandom_range(0, 3));
        for (int k = 0; k < 2000; k++) begin
            logic [2:0] nl;
            nl = lvl;
            if ($urandom_range(0, 99) < 2) nl = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 9) < 8), ($urandom_range(0, 199) == 0), nl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
